// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 encryptor: byte type, top-level and swap-engine state encodings.
// Optional build macro ARC4_DROP_EN adds the keystream-discard default.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int KEY_BYTES_DEF = 3;
`ifdef ARC4_DROP_EN
  localparam int DROP_N_DEF = 16;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_LEN_RD,
    ST_LEN_WR,
    ST_DROP,
    ST_PRGA_SWAP,
    ST_PRGA_RD,
    ST_PRGA_WR,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_RD_I,
    SW_WAIT_I,
    SW_RD_J,
    SW_WAIT_J,
    SW_WR_I,
    SW_WR_J
  } swap_state_e;

endpackage

// File: rtl/arc4_swap.sv
// Read-read-write-write swap of S[a] and S[b] on a single-port S RAM, where
// b = jbase + addend + S[a]; returns the pre-swap S[a], S[b] and the new index b.
module arc4_swap
  import arc4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start_i,
  input  byte_t a_i,
  input  byte_t jbase_i,
  input  byte_t addend_i,
  input  byte_t s_rddata_i,
  output byte_t s_addr_o,
  output byte_t s_wrdata_o,
  output logic  s_wren_o,
  output logic  busy_o,
  output logic  done_o,
  output byte_t si_o,
  output byte_t sj_o,
  output byte_t b_o
);

  swap_state_e state_q, state_d;
  byte_t a_q, a_d;
  byte_t jb_q, jb_d;
  byte_t b_q, b_d;
  byte_t si_q, si_d;
  byte_t sj_q, sj_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SW_IDLE;
    end else begin
      state_q <= state_d;
    end
    a_q  <= a_d;
    jb_q <= jb_d;
    b_q  <= b_d;
    si_q <= si_d;
    sj_q <= sj_d;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    jb_d       = jb_q;
    b_d        = b_q;
    si_d       = si_q;
    sj_d       = sj_q;
    s_addr_o   = '0;
    s_wrdata_o = '0;
    s_wren_o   = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q != SW_IDLE);
    case (state_q)
      SW_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          jb_d    = jbase_i + addend_i;
          state_d = SW_RD_I;
        end
      end
      SW_RD_I: begin
        s_addr_o = a_q;
        state_d  = SW_WAIT_I;
      end
      SW_WAIT_I: begin
        si_d    = s_rddata_i;
        b_d     = jb_q + s_rddata_i;
        state_d = SW_RD_J;
      end
      SW_RD_J: begin
        s_addr_o = b_q;
        state_d  = SW_WAIT_J;
      end
      SW_WAIT_J: begin
        sj_d    = s_rddata_i;
        state_d = SW_WR_I;
      end
      // When a == b both writes carry the same byte, so S[a] is left unchanged.
      SW_WR_I: begin
        s_addr_o   = a_q;
        s_wrdata_o = sj_q;
        s_wren_o   = 1'b1;
        state_d    = SW_WR_J;
      end
      SW_WR_J: begin
        s_addr_o   = b_q;
        s_wrdata_o = si_q;
        s_wren_o   = 1'b1;
        done_o     = 1'b1;
        state_d    = SW_IDLE;
      end
      default: state_d = SW_IDLE;
    endcase
  end

  assign si_o = si_q;
  assign sj_o = sj_q;
  assign b_o  = b_q;

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: INIT, KSA, length copy, optional keystream discard (ARC4_DROP_EN), PRGA.
// Streams a length-prefixed plaintext from the pt RAM into a length-prefixed ct image.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
`ifdef ARC4_DROP_EN
  , parameter int DROP_N = DROP_N_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output byte_t                  s_addr,
  input  byte_t                  s_rddata,
  output byte_t                  s_wrdata,
  output logic                   s_wren,
  output byte_t                  pt_addr,
  input  byte_t                  pt_rddata,
  output byte_t                  ct_addr,
  output byte_t                  ct_wrdata,
  output logic                   ct_wren
);

  function automatic byte_t key_byte(input logic [8*KEY_BYTES-1:0] kv, input byte_t idx);
    byte_t r;
    r = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (idx == byte_t'(n)) r = kv[8*(KEY_BYTES-1-n) +: 8];
    end
    return r;
  endfunction

  state_e state_q, state_d;
  byte_t  i_q, i_d;
  byte_t  j_q, j_d;
  byte_t  k_q, k_d;
  byte_t  kidx_q, kidx_d;
  byte_t  len_q, len_d;
  byte_t  t_q, t_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
`ifdef ARC4_DROP_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  byte_t top_s_addr, top_s_wrdata;
  logic  top_s_wren;
  logic  sw_start, sw_busy, sw_done, sw_wren;
  byte_t sw_a, sw_add, sw_addr, sw_wrdata, sw_si, sw_sj, sw_b;

  // KSA swaps S[i] with key mixing; DROP/PRGA pre-increment i and add no key.
  assign sw_a   = (state_q == ST_KSA) ? i_q : i_q + 8'd1;
  assign sw_add = (state_q == ST_KSA) ? key_byte(key_q, kidx_q) : 8'd0;

  arc4_swap u_swap (
    .clk        (clk),
    .rst        (rst),
    .start_i    (sw_start),
    .a_i        (sw_a),
    .jbase_i    (j_q),
    .addend_i   (sw_add),
    .s_rddata_i (s_rddata),
    .s_addr_o   (sw_addr),
    .s_wrdata_o (sw_wrdata),
    .s_wren_o   (sw_wren),
    .busy_o     (sw_busy),
    .done_o     (sw_done),
    .si_o       (sw_si),
    .sj_o       (sw_sj),
    .b_o        (sw_b)
  );

  assign s_addr   = sw_busy ? sw_addr   : top_s_addr;
  assign s_wrdata = sw_busy ? sw_wrdata : top_s_wrdata;
  assign s_wren   = sw_busy ? sw_wren   : top_s_wren;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kidx_q  <= '0;
`ifdef ARC4_DROP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kidx_q  <= kidx_d;
`ifdef ARC4_DROP_EN
      cnt_q   <= cnt_d;
`endif
    end
    key_q <= key_d;
    len_q <= len_d;
    t_q   <= t_d;
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    kidx_d       = kidx_q;
    key_d        = key_q;
    len_d        = len_q;
    t_d          = t_q;
`ifdef ARC4_DROP_EN
    cnt_d        = cnt_q;
`endif
    rdy          = 1'b0;
    sw_start     = 1'b0;
    top_s_addr   = '0;
    top_s_wrdata = '0;
    top_s_wren   = 1'b0;
    pt_addr      = '0;
    ct_addr      = '0;
    ct_wrdata    = '0;
    ct_wren      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        rdy     = 1'b1;
        state_d = ST_IDLE;
        if (en) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        top_s_addr   = i_q;
        top_s_wrdata = i_q;
        top_s_wren   = 1'b1;
        i_d          = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = ST_KSA;
        end
      end
      ST_KSA: begin
        sw_start = 1'b1;
        if (sw_done) begin
          i_d    = i_q + 8'd1;
          j_d    = sw_b;
          kidx_d = (kidx_q == byte_t'(KEY_BYTES-1)) ? 8'd0 : kidx_q + 8'd1;
          if (i_q == 8'hFF) state_d = ST_LEN_RD;
        end
      end
      ST_LEN_RD: begin
        pt_addr = '0;
        state_d = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        ct_addr   = '0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        len_d     = pt_rddata;
        i_d       = '0;
        j_d       = '0;
        k_d       = 8'd1;
        if (pt_rddata == 8'd0) begin
          state_d = ST_DONE;
        end else begin
`ifdef ARC4_DROP_EN
          cnt_d   = '0;
          state_d = ST_DROP;
`else
          state_d = ST_PRGA_SWAP;
`endif
        end
      end
`ifdef ARC4_DROP_EN
      ST_DROP: begin
        sw_start = 1'b1;
        if (sw_done) begin
          i_d   = i_q + 8'd1;
          j_d   = sw_b;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'(DROP_N - 1)) state_d = ST_PRGA_SWAP;
        end
      end
`endif
      // Post-swap S[i]+S[j] equals the sum of the two pre-swap bytes.
      ST_PRGA_SWAP: begin
        sw_start = 1'b1;
        if (sw_done) begin
          i_d     = i_q + 8'd1;
          j_d     = sw_b;
          t_d     = sw_si + sw_sj;
          state_d = ST_PRGA_RD;
        end
      end
      ST_PRGA_RD: begin
        top_s_addr = t_q;
        pt_addr    = k_q;
        state_d    = ST_PRGA_WR;
      end
      ST_PRGA_WR: begin
        ct_addr   = k_q;
        ct_wrdata = pt_rddata ^ s_rddata;
        ct_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = ST_PRGA_SWAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural RAMs, a plain software ARC4 model and a per-write checker.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst, en, rdy;
  logic [23:0] key;
  logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic        s_wren, ct_wren;

`ifdef ARC4_DROP_EN
  localparam int TB_DROP = 16;
`else
  localparam int TB_DROP = 0;
`endif

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  logic [7:0] smem  [256];
  logic [7:0] ptmem [256];
  logic [7:0] ctmem [256];
  logic [7:0] s_addr_r, pt_addr_r;
  logic       ct_clr = 1'b0;

  always @(posedge clk) begin
    if (s_wren) smem[s_addr] <= s_wrdata;
    if (ct_clr) begin
      for (int n = 0; n < 256; n++) ctmem[n] <= 8'hEE;
    end else if (ct_wren) begin
      ctmem[ct_addr] <= ct_wrdata;
    end
    s_addr_r  <= s_addr;
    pt_addr_r <= pt_addr;
  end
  assign s_rddata  = smem[s_addr_r];
  assign pt_rddata = ptmem[pt_addr_r];

  int checks = 0, failures = 0;
  int cyc = 0, s_wr_cnt = 0, ct_wr_cnt = 0;
  int t_start = 0, wr_base = 0, cur_len = 0, last_lat = 0;
  logic [7:0] exp_a[$], exp_d[$];
  logic [7:0] ks[256];
  logic [7:0] exp_ct[256];
  bit exp_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Textbook ARC4 keystream, optionally with the first `drop` bytes discarded.
  task automatic gen_ks(input logic [23:0] k, input int drop);
    int s[256];
    int i, j, tmp;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(k[8*(2-(n%3)) +: 8])) % 256;
      tmp = s[n]; s[n] = s[j]; s[j] = tmp;
    end
    i = 0; j = 0;
    for (int n = 0; n < drop + 256; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      if (n >= drop) ks[n-drop] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Every ct write is checked against the next expected (address, byte) pair.
  initial begin
    logic [7:0] ea, ed;
    forever begin
      @(negedge clk);
      if (exp_rdy) begin
        chk("rdy_after_last_wr", 32'(rdy), 32'd1);
        exp_rdy = 1'b0;
      end
      if (s_wren) s_wr_cnt++;
      if (ct_wren) begin
        ct_wr_cnt++;
        if (exp_a.size() == 0) begin
          chk("ct_unexpected_wr", 32'(ct_addr) + 32'h100, 32'd0);
        end else begin
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          chk("ct_addr", 32'(ct_addr), 32'(ea));
          chk("ct_data", 32'(ct_wrdata), 32'(ed));
          if (exp_a.size() == 0) exp_rdy = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input logic [23:0] k, input string name);
    cur_len = int'(ptmem[0]);
    gen_ks(k, TB_DROP);
    exp_a.delete();
    exp_d.delete();
    for (int n = 0; n < 256; n++) exp_ct[n] = 8'hEE;
    exp_ct[0] = ptmem[0];
    exp_a.push_back(8'd0);
    exp_d.push_back(ptmem[0]);
    for (int n = 1; n <= cur_len; n++) begin
      exp_ct[n] = ptmem[n] ^ ks[n-1];
      exp_a.push_back(8'(n));
      exp_d.push_back(exp_ct[n]);
    end
    @(negedge clk);
    ct_clr = 1'b1;
    @(negedge clk);
    ct_clr  = 1'b0;
    wr_base = ct_wr_cnt;
    en      = 1'b1;
    key     = k;
    @(negedge clk);
    en      = 1'b0;
    t_start = cyc;
    chk({name, "_rdy_low"}, 32'(rdy), 32'd0);
  endtask

  task automatic finish_run(input string name);
    int n, mism;
    n = 0;
    while (rdy !== 1'b1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(rdy), 32'd1);
    last_lat = cyc - t_start;
    chk({name, "_wr_count"}, 32'(ct_wr_cnt - wr_base), 32'(cur_len + 1));
    chk({name, "_pending"}, 32'(exp_a.size()), 32'd0);
    mism = 0;
    for (int m = 0; m < 256; m++) if (ctmem[m] !== exp_ct[m]) mism++;
    chk({name, "_ct_image"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int sb, cb, n;
    string pts, hel;
    logic [71:0] pin;
    rst = 1'b1; en = 1'b0; key = '0;
    for (int m = 0; m < 256; m++) ptmem[m] = 8'h00;

    // Reset then idle.
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_s_wren", 32'(s_wren), 32'd0);
    chk("rst_ct_wren", 32'(ct_wren), 32'd0);
    chk("rst_addrs", {8'(s_addr), 8'(pt_addr), 8'(ct_addr), 8'(s_wrdata | ct_wrdata)}, 32'd0);
    rst = 1'b0;
    sb = s_wr_cnt; cb = ct_wr_cnt;
    repeat (50) @(negedge clk);
    chk("idle_s_writes", 32'(s_wr_cnt - sb), 32'd0);
    chk("idle_ct_writes", 32'(ct_wr_cnt - cb), 32'd0);
    chk("idle_rdy", 32'(rdy), 32'd1);

    // Model pinned to the published vector: key "Key", plaintext "Plaintext".
    pts = "Plaintext";
    pin = 72'hBBF316E8D940AF0AD3;
    gen_ks(24'h4B6579, 0);
    for (int m = 0; m < 9; m++) chk("model_pin", 32'(8'(pts[m]) ^ ks[m]), 32'(pin[8*(8-m) +: 8]));
    ptmem[0] = 8'd9;
    for (int m = 0; m < 9; m++) ptmem[m+1] = 8'(pts[m]);
    start_run(24'h4B6579, "vec");
    finish_run("vec");
`ifndef ARC4_DROP_EN
    for (int m = 0; m < 9; m++) chk("vec_literal", 32'(ctmem[m+1]), 32'(pin[8*(8-m) +: 8]));
`endif

    // "\x05hello" with key 0x000018.
    hel = "hello";
    ptmem[0] = 8'd5;
    for (int m = 0; m < 5; m++) ptmem[m+1] = 8'(hel[m]);
    start_run(24'h000018, "hello");
    finish_run("hello");
    chk("hello_len", 32'(ctmem[0]), 32'd5);
    for (int m = 0; m < 5; m++) chk("hello_decrypt", 32'(ctmem[m+1] ^ ks[m]), 32'(8'(hel[m])));

    // Zero-length message.
    ptmem[0] = 8'd0;
    start_run(24'h5A5A5A, "len0");
    finish_run("len0");
    chk("len0_ct0", 32'(ctmem[0]), 32'd0);
    chk("len0_latency_min", 32'(last_lat >= 256 + 256*6), 32'd1);

    // Maximum-length random message, all-ones key.
    ptmem[0] = 8'd255;
    for (int m = 1; m < 256; m++) ptmem[m] = 8'($urandom_range(0, 255));
    start_run(24'hFFFFFF, "len255");
    finish_run("len255");

    // en pulses during KSA and PRGA are ignored.
    ptmem[0] = 8'd20;
    for (int m = 1; m <= 20; m++) ptmem[m] = 8'($urandom_range(0, 255));
    start_run(24'hA5C3E1, "enpulse");
    repeat (700) @(negedge clk);
    en = 1'b1; key = 24'h123456;
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (ct_wr_cnt - wr_base < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    finish_run("enpulse");
    sb = s_wr_cnt; cb = ct_wr_cnt;
    repeat (40) @(negedge clk);
    chk("enpulse_no_rerun_s", 32'(s_wr_cnt - sb), 32'd0);
    chk("enpulse_no_rerun_ct", 32'(ct_wr_cnt - cb), 32'd0);

    // Reset while k=3 is in flight, then rerun with the same inputs.
    ptmem[0] = 8'd12;
    for (int m = 1; m <= 12; m++) ptmem[m] = 8'($urandom_range(0, 255));
    start_run(24'h0F1E2D, "abort");
    n = 0;
    while (ct_wr_cnt - wr_base < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_k3", 32'(ct_wr_cnt - wr_base), 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_wren", {30'd0, s_wren, ct_wren}, 32'd0);
    rst = 1'b0;
    exp_a.delete();
    exp_d.delete();
    sb = s_wr_cnt; cb = ct_wr_cnt;
    repeat (30) @(negedge clk);
    chk("abort_quiet_s", 32'(s_wr_cnt - sb), 32'd0);
    chk("abort_quiet_ct", 32'(ct_wr_cnt - cb), 32'd0);
    chk("abort_wr_total", 32'(ct_wr_cnt - wr_base), 32'd3);
    start_run(24'h0F1E2D, "rerun");
    finish_run("rerun");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
